// File: rtl/rv32_writeback_unit.sv
// RV32 writeback stage: retires ALU/LINK/NOWB in one cycle, waits for, aligns and extends load data.
// Defining RV32_WB_INSTRET_EN adds the `instret` retire-counter output.
module rv32_writeback_unit #(
  parameter int unsigned LOAD_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_result,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  wb_reg,
  output logic        wb_en,
  output logic [31:0] wb_val,
  output logic        load_err,
  output logic        busy
`ifdef RV32_WB_INSTRET_EN
  ,
  output logic [CNT_W-1:0] instret
`endif
);

  typedef enum logic {IDLE, LOAD_WAIT} state_e;
  typedef enum logic [1:0] {
    KIND_ALU  = 2'b00,
    KIND_LOAD = 2'b01,
    KIND_LINK = 2'b10,
    KIND_NOWB = 2'b11
  } kind_e;

  localparam int unsigned TW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'((LOAD_TIMEOUT == 0) ? 32'd0 : LOAD_TIMEOUT - 32'd1);

  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  state_e        state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [4:0]    ld_rd;
  logic [2:0]    ld_f3;
  logic [1:0]    ld_lo;
  logic          latch_ld, transfer, timeout_hit;
  logic          wb_en_n, load_err_n;
  logic [4:0]    wb_reg_n;
  logic [31:0]   wb_val_n;

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lo,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[8*lo +: 8];
    h = w[16*lo[1] +: 16];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign in_ready    = (state == IDLE) && !rst;
  assign transfer    = in_valid && in_ready;
  assign busy        = (state == LOAD_WAIT);
  assign timeout_hit = (LOAD_TIMEOUT != 0) && (tcnt == TMAX);

  always_comb begin
    state_n    = state;
    tcnt_n     = tcnt;
    latch_ld   = 1'b0;
    wb_en_n    = 1'b0;
    wb_reg_n   = wb_reg;
    wb_val_n   = wb_val;
    load_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (transfer) begin
          case (kind_e'(in_kind))
            KIND_ALU, KIND_LINK: begin
              if (in_rd != '0) begin
                wb_en_n  = 1'b1;
                wb_reg_n = in_rd;
                wb_val_n = in_result;
              end
            end
            KIND_LOAD: begin
              latch_ld = 1'b1;
              tcnt_n   = '0;
              state_n  = LOAD_WAIT;
            end
            default: ;
          endcase
        end
      end
      LOAD_WAIT: begin
        // A response in the timeout cycle takes priority over abandoning the load.
        if (mem_rvalid) begin
          if (ld_rd != '0) begin
            wb_en_n  = 1'b1;
            wb_reg_n = ld_rd;
            wb_val_n = extract(ld_f3, ld_lo, mem_rdata);
          end
          state_n = IDLE;
        end else if (timeout_hit) begin
          load_err_n = 1'b1;
          state_n    = IDLE;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tcnt     <= '0;
      ld_rd    <= '0;
      ld_f3    <= '0;
      ld_lo    <= '0;
      wb_en    <= 1'b0;
      wb_reg   <= '0;
      wb_val   <= '0;
      load_err <= 1'b0;
    end else begin
      state    <= state_n;
      tcnt     <= tcnt_n;
      wb_en    <= wb_en_n;
      wb_reg   <= wb_reg_n;
      wb_val   <= wb_val_n;
      load_err <= load_err_n;
      if (latch_ld) begin
        ld_rd <= in_rd;
        ld_f3 <= in_funct3;
        ld_lo <= in_addr_lo;
      end
    end
  end

`ifdef RV32_WB_INSTRET_EN
  logic retire;

  // Counts every retirement, including rd=0 writes, NOWB and abandoned loads.
  assign retire = (state == IDLE) ? (transfer && (kind_e'(in_kind) != KIND_LOAD))
                                  : (mem_rvalid || timeout_hit);

  always_ff @(posedge clk) begin
    if (rst)         instret <= '0;
    else if (retire) instret <= instret + 1'b1;
  end
`endif

endmodule

// File: tb/tb_rv32_writeback_unit.sv
// Scoreboard bench for rv32_writeback_unit: directed plus random retirements against a behavioural model.
module tb_rv32_writeback_unit;

  localparam int unsigned LT   = 16;
  localparam int unsigned CW   = 64;
  localparam int          MAXC = 20000;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, mem_rvalid, wb_en, load_err, busy;
  logic [1:0]  in_kind, in_addr_lo;
  logic [4:0]  in_rd, wb_reg;
  logic [31:0] in_result, mem_rdata, wb_val;
  logic [2:0]  in_funct3;
`ifdef RV32_WB_INSTRET_EN
  logic [CW-1:0] instret;
`endif

  rv32_writeback_unit #(.LOAD_TIMEOUT(LT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_result(in_result),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_reg(wb_reg), .wb_en(wb_en), .wb_val(wb_val),
    .load_err(load_err), .busy(busy)
`ifdef RV32_WB_INSTRET_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] data;
    int          delay;
    int          gap;
    bit          rst_mid;
  } stim_t;

  typedef struct {
    int          stamp;
    bit          is_err;
    logic [4:0]  rd;
    logic [31:0] val;
  } ev_t;

  stim_t stim_q[$];
  ev_t   exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  logic  rst_q = 1'b1;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference load formatting: shift the addressed lane down, then sign/zero extend arithmetically.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    longint v;
    case (f3)
      3'b000, 3'b100: begin
        v = longint'((w >> (8 * int'(lo))) & 32'hFF);
        if (f3 == 3'b000 && v > 127) v = v - 256;
      end
      3'b001, 3'b101: begin
        v = longint'((w >> ((lo >= 2'd2) ? 16 : 0)) & 32'hFFFF);
        if (f3 == 3'b001 && v > 32767) v = v - 65536;
      end
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  function automatic stim_t mk(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] res,
                               input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] data,
                               input int delay, input int gap, input bit rst_mid);
    stim_t s;
    s.kind = kind; s.rd = rd; s.res = res; s.f3 = f3; s.lo = lo;
    s.data = data; s.delay = delay; s.gap = gap; s.rst_mid = rst_mid;
    return s;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a write or a load error.
  logic [4:0]  hold_reg = '0;
  logic [31:0] hold_val = '0;

  always @(negedge clk) begin
    if (rst_q) begin
      chk("reset wb_en", 64'(wb_en), 64'd0);
      chk("reset load_err", 64'(load_err), 64'd0);
      chk("reset wb_reg", 64'(wb_reg), 64'd0);
      chk("reset wb_val", 64'(wb_val), 64'd0);
      hold_reg = '0;
      hold_val = '0;
      while (exp_q.size() != 0 && exp_q[0].stamp <= cyc) void'(exp_q.pop_front());
    end else if (wb_en || load_err) begin
      if (exp_q.size() == 0 || exp_q[0].stamp != cyc) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event @cyc %0d: got wb_en=%0b load_err=%0b reg=%0d val=%h expected none",
                 cyc, wb_en, load_err, wb_reg, wb_val);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("event load_err", 64'(load_err), 64'(e.is_err));
        chk("event wb_en", 64'(wb_en), 64'(!e.is_err));
        if (!e.is_err) begin
          chk("wb_reg", 64'(wb_reg), 64'(e.rd));
          chk("wb_val", 64'(wb_val), 64'(e.val));
          hold_reg = e.rd;
          hold_val = e.val;
        end
      end
    end else begin
      if (exp_q.size() != 0 && exp_q[0].stamp == cyc) begin
        ev_t e;
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_event @cyc %0d: got no event expected err=%0b reg=%0d val=%h",
                 cyc, e.is_err, e.rd, e.val);
      end
      chk("hold wb_reg", 64'(wb_reg), 64'(hold_reg));
      chk("hold wb_val", 64'(wb_val), 64'(hold_val));
    end
  end

  // Driver and reference model. Model state is the architectural view: idle or waiting on a load.
  initial begin
    stim_t  cur, ld;
    bit     cur_valid = 0, pending = 0, post_rst = 0, done = 0;
    int     gap = 0, ld_k = 0, drain = 0, c = 0;
    longint exp_instret = 0;

    // Directed cases from the plan, then randomized traffic.
    stim_q.push_back(mk(2'b00, 5'd5, 32'h12345678, 3'd0, 2'd0, 32'd0, 0, 0, 0));
    stim_q.push_back(mk(2'b00, 5'd6, 32'hCAFEBABE, 3'd0, 2'd0, 32'd0, 0, 1, 0));
    stim_q.push_back(mk(2'b00, 5'd0, 32'hFFFFFFFF, 3'd0, 2'd0, 32'd0, 0, 1, 0));
    stim_q.push_back(mk(2'b01, 5'd10, 32'd0, 3'b000, 2'd3, 32'h80FF7F01, 2, 0, 0));
    stim_q.push_back(mk(2'b01, 5'd11, 32'd0, 3'b101, 2'd2, 32'h80FF7F01, 0, 0, 0));
    stim_q.push_back(mk(2'b01, 5'd12, 32'd0, 3'b001, 2'd1, 32'h80FF7F01, 1, 1, 0));
    stim_q.push_back(mk(2'b01, 5'd9, 32'd0, 3'b010, 2'd0, 32'h11111111, LT + 5, 1, 0));
    stim_q.push_back(mk(2'b01, 5'd13, 32'd0, 3'b010, 2'd0, 32'h5A5AA5A5, LT - 1, 1, 0));
    stim_q.push_back(mk(2'b01, 5'd7, 32'd0, 3'b010, 2'd0, 32'h0, 6, 2, 1));
    stim_q.push_back(mk(2'b01, 5'd4, 32'd0, 3'b100, 2'd1, 32'h00C30000, 3, 0, 0));
    stim_q.push_back(mk(2'b00, 5'd3, 32'h0BADF00D, 3'd0, 2'd0, 32'd0, 0, 0, 0));
    stim_q.push_back(mk(2'b10, 5'd1, 32'h00001004, 3'd0, 2'd0, 32'd0, 0, 0, 0));
    stim_q.push_back(mk(2'b11, 5'd12, 32'h77777777, 3'd0, 2'd0, 32'd0, 0, 1, 0));
    for (int i = 0; i < 300; i++) begin
      stim_t s;
      s.kind    = 2'($urandom_range(0, 3));
      s.rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      s.res     = $urandom;
      s.f3      = 3'($urandom_range(0, 7));
      s.lo      = 2'($urandom_range(0, 3));
      s.data    = $urandom;
      s.delay   = ($urandom_range(0, 5) == 0) ? $urandom_range(LT - 2, LT + 3) : $urandom_range(0, 4);
      s.gap     = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
      s.rst_mid = (s.kind == 2'b01) && (s.delay >= 3) && ($urandom_range(0, 19) == 0);
      stim_q.push_back(s);
    end

    rst = 1'b1; in_valid = 1'b0; in_kind = '0; in_rd = '0; in_result = '0;
    in_funct3 = '0; in_addr_lo = '0; mem_rvalid = 1'b0; mem_rdata = '0;

    while (!done) begin
      rst = (c < 2) || (pending && ld.rst_mid && ld_k == 1);

      if (!cur_valid) begin
        if (gap > 0) gap--;
        else if (stim_q.size() != 0) begin
          cur = stim_q.pop_front();
          cur_valid = 1;
        end
      end
      in_valid   = cur_valid;
      in_kind    = cur_valid ? cur.kind : 2'($urandom);
      in_rd      = cur_valid ? cur.rd   : 5'($urandom);
      in_result  = cur_valid ? cur.res  : $urandom;
      in_funct3  = cur_valid ? cur.f3   : 3'($urandom);
      in_addr_lo = cur_valid ? cur.lo   : 2'($urandom);

      if (pending) begin
        mem_rvalid = (ld_k == ld.delay);
        mem_rdata  = mem_rvalid ? ld.data : $urandom;
      end else if (post_rst) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        post_rst   = 0;
      end else begin
        mem_rvalid = ($urandom_range(0, 3) == 0);
        mem_rdata  = $urandom;
      end

      @(negedge clk);
      chk("in_ready", 64'(in_ready), 64'(!pending && !rst));
      chk("busy", 64'(busy), 64'(pending));
`ifdef RV32_WB_INSTRET_EN
      chk("instret", 64'(instret), 64'(exp_instret));
`endif

      if (rst) begin
        if (pending) post_rst = 1;
        pending     = 0;
        exp_instret = 0;
      end else if (pending) begin
        if (mem_rvalid) begin
          if (ld.rd != 0) exp_q.push_back('{cyc + 1, 1'b0, ld.rd, ref_load(ld.f3, ld.lo, ld.data)});
          exp_instret++;
          pending = 0;
        end else if (LT != 0 && ld_k == int'(LT) - 1) begin
          exp_q.push_back('{cyc + 1, 1'b1, 5'd0, 32'd0});
          exp_instret++;
          pending = 0;
        end else begin
          ld_k++;
        end
      end else if (in_valid) begin
        cur_valid = 0;
        gap       = cur.gap;
        if (cur.kind == 2'b01) begin
          pending = 1;
          ld_k    = 0;
          ld      = cur;
        end else begin
          exp_instret++;
          if (cur.kind != 2'b11 && cur.rd != 0) exp_q.push_back('{cyc + 1, 1'b0, cur.rd, cur.res});
        end
      end

      @(posedge clk);
      #1;
      c++;
      if (stim_q.size() == 0 && !cur_valid && !pending && !post_rst) drain++;
      if (drain >= 4) done = 1;
      if (c >= MAXC) begin
        checks++;
        errors++;
        $display("FAIL cycle_budget: got %0d cycles expected completion before %0d", c, MAXC);
        done = 1;
      end
    end

    @(negedge clk);
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
